// File: rtl/regfile_sb_bypass_pkg.sv
// Shared definitions for the bypassing register file: sweep FSM encoding and parameter defaults.
package regfile_sb_bypass_pkg;

  typedef enum logic {
    StClear = 1'b0,
    StReady = 1'b1
  } rf_state_e;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;
  localparam int unsigned MaxNumRd = 4;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one bit per register, set on issue, cleared on write-back, cleared by flush.
module regfile_scoreboard
  import regfile_sb_bypass_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_RD*ADDR_W-1:0] id_rR,
  input  logic                     id_set,
  input  logic [ADDR_W-1:0]        id_setR,
  input  logic                     id_flush,
  input  logic                     wb_we,
  input  logic [ADDR_W-1:0]        wb_wR,
  output logic [NUM_RD-1:0]        id_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;

  // Flush beats issue, and issue beats a same-cycle write-back clear of the same register.
  always_comb begin
    busy_d = busy_q;
    if (en) begin
      if (id_flush) begin
        busy_d = '0;
      end else begin
        if (wb_we) busy_d[wb_wR] = 1'b0;
        if (id_set && !(ZERO_REG && id_setR == '0)) busy_d[id_setR] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    logic [ADDR_W-1:0] ra;
    logic              fwd;
    assign ra  = id_rR[k*ADDR_W +: ADDR_W];
    // A producer writing back this very cycle is forwarded, so it no longer blocks the reader.
    assign fwd = BYPASS && wb_we && (wb_wR == ra);
    assign id_busy[k] = en && busy_q[ra] && !fwd && !(ZERO_REG && ra == '0);
  end

endmodule

// File: rtl/regfile_sb_bypass.sv
// Pipeline register file: NUM_RD combinational reads, one write port, optional bypass and R0,
// busy scoreboard, and a post-reset sweep that zeroes the reset-less storage.
module regfile_sb_bypass
  import regfile_sb_bypass_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_done,
  input  logic [NUM_RD*ADDR_W-1:0] id_rR,
  output logic [NUM_RD*DATA_W-1:0] id_rD,
  output logic [NUM_RD-1:0]        id_busy,
  input  logic                     id_set,
  input  logic [ADDR_W-1:0]        id_setR,
  input  logic                     id_flush,
  input  logic                     wb_we,
  input  logic [ADDR_W-1:0]        wb_wR,
  input  logic [DATA_W-1:0]        wb_wD
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  if (NUM_RD < 1 || NUM_RD > MaxNumRd) begin : g_bad_num_rd
    $error("NUM_RD out of range");
  end

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = wb_wR;
    mem_wdata = wb_wD;
    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + ADDR_W'(1);
        if (&cnt_q) state_d = StReady;
      end
      StReady: begin
        mem_we = wb_we && !(ZERO_REG && wb_wR == '0);
      end
    endcase
  end

  // No reset on the array so it can map onto RAM; the sweep provides the zeroing.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

  assign ready     = (state_q == StReady);
  assign init_done = ready;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    assign ra = id_rR[k*ADDR_W +: ADDR_W];
    always_comb begin
      rd = mem[ra];
      if (!ready || (ZERO_REG && ra == '0)) rd = '0;
      else if (BYPASS && wb_we && wb_wR == ra) rd = wb_wD;
    end
    assign id_rD[k*DATA_W +: DATA_W] = rd;
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .BYPASS  (BYPASS),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .en      (ready),
    .id_rR   (id_rR),
    .id_set  (id_set),
    .id_setR (id_setR),
    .id_flush(id_flush),
    .wb_we   (wb_we),
    .wb_wR   (wb_wR),
    .id_busy (id_busy)
  );

endmodule

// File: tb/tb_regfile_sb_bypass.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a negedge monitor checks them.
module tb_regfile_sb_bypass;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  id_rR;
  logic        id_set;
  logic [4:0]  id_setR;
  logic        id_flush;
  logic        wb_we;
  logic [4:0]  wb_wR;
  logic [31:0] wb_wD;

  logic        init_done, nb_init_done;
  logic [63:0] rd, nb_rd;
  logic [1:0]  busy, nb_busy;

  always #5 clk = ~clk;

  regfile_sb_bypass #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .id_rR(id_rR), .id_rD(rd), .id_busy(busy),
    .id_set(id_set), .id_setR(id_setR), .id_flush(id_flush),
    .wb_we(wb_we), .wb_wR(wb_wR), .wb_wD(wb_wD)
  );

  regfile_sb_bypass #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_nb (
    .clk(clk), .rst(rst), .init_done(nb_init_done), .id_rR(id_rR), .id_rD(nb_rd),
    .id_busy(nb_busy), .id_set(id_set), .id_setR(id_setR), .id_flush(id_flush),
    .wb_we(wb_we), .wb_wR(wb_wR), .wb_wD(wb_wD)
  );

  localparam int SelRd0 = 0, SelRd1 = 1, SelBusy = 2, SelInit = 3;
  localparam int SelNbRd0 = 4, SelNbBusy = 5, SelNbInit = 6;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic expect_val(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    q.push_back(e);
  endtask

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      SelRd0:    return rd[31:0];
      SelRd1:    return rd[63:32];
      SelBusy:   return {30'b0, busy};
      SelInit:   return {31'b0, init_done};
      SelNbRd0:  return nb_rd[31:0];
      SelNbBusy: return {30'b0, nb_busy};
      default:   return {31'b0, nb_init_done};
    endcase
  endfunction

  // Monitor: the combinational outputs are stable by the falling edge.
  always @(negedge clk) begin
    while (q.size() != 0) begin
      exp_t e;
      logic [31:0] act;
      e   = q.pop_front();
      act = pick(e.sel);
      n_cmp++;
      if (act !== e.val) begin
        n_err++;
        $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_addr(input logic [4:0] p0, input logic [4:0] p1);
    id_rR = {p1, p0};
  endtask

  task automatic sweep_check(input int cycles, input string tag);
    for (int c = 1; c <= cycles; c++) begin
      step();
      if (c == 31 || c == 32 || c == 1 || c == 10)
        expect_val($sformatf("%s_init_c%0d", tag, c), SelInit, {31'b0, c == 32});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; id_rR = '0; id_set = 1'b0; id_setR = '0; id_flush = 1'b0;
    wb_we = 1'b0; wb_wR = '0; wb_wD = '0;
    step();
    rst = 1'b0;
    rd_addr(5'd5, 5'd31);
    expect_val("rst_init", SelInit, 32'd0);
    expect_val("rst_rd0", SelRd0, 32'd0);
    expect_val("rst_busy", SelBusy, 32'd0);

    // Initial sweep, with a write and issue attempted mid-sweep (both must be dropped).
    for (int c = 1; c <= 32; c++) begin
      step();
      wb_we = 1'b0; id_set = 1'b0;
      if (c == 20) begin
        wb_we = 1'b1; wb_wR = 5'd5; wb_wD = 32'hAAAA5555;
        id_set = 1'b1; id_setR = 5'd5;
        expect_val("clear_rd0_nobypass", SelRd0, 32'd0);
        expect_val("clear_busy", SelBusy, 32'd0);
      end
      if (c == 1 || c == 31 || c == 32)
        expect_val($sformatf("sweep_init_c%0d", c), SelInit, {31'b0, c == 32});
    end
    expect_val("sweep_nb_init", SelNbInit, 32'd1);
    expect_val("clear_write_dropped", SelRd0, 32'd0);
    expect_val("clear_set_dropped", SelBusy, 32'd0);

    // Same-cycle write-through versus registered read.
    step();
    wb_we = 1'b1; wb_wR = 5'd5; wb_wD = 32'hDEADBEEF;
    rd_addr(5'd5, 5'd6);
    expect_val("bypass_rd0", SelRd0, 32'hDEADBEEF);
    expect_val("nobypass_rd0", SelNbRd0, 32'd0);
    expect_val("bypass_rd1_other", SelRd1, 32'd0);
    step();
    wb_we = 1'b0;
    rd_addr(5'd5, 5'd5);
    expect_val("written_rd0", SelRd0, 32'hDEADBEEF);
    expect_val("written_rd1_same", SelRd1, 32'hDEADBEEF);
    expect_val("written_nb_rd0", SelNbRd0, 32'hDEADBEEF);

    // R0 is hardwired and never busy.
    step();
    wb_we = 1'b1; wb_wR = 5'd0; wb_wD = 32'h1234;
    rd_addr(5'd0, 5'd0);
    expect_val("r0_write_bypass", SelRd0, 32'd0);
    step();
    wb_we = 1'b0; id_set = 1'b1; id_setR = 5'd0;
    expect_val("r0_after_write", SelRd0, 32'd0);
    step();
    id_set = 1'b0;
    expect_val("r0_busy", SelBusy, 32'd0);

    // Issue/write-back hazard on R7.
    step();
    id_set = 1'b1; id_setR = 5'd7;
    rd_addr(5'd7, 5'd7);
    expect_val("set_not_yet_visible", SelBusy, 32'd0);
    step();
    id_set = 1'b0;
    expect_val("r7_busy_t1", SelBusy, 32'd3);
    step();
    expect_val("r7_busy_t2", SelBusy, 32'd3);
    step();
    wb_we = 1'b1; wb_wR = 5'd7; wb_wD = 32'd77;
    expect_val("r7_wb_bypass_busy", SelBusy, 32'd0);
    expect_val("r7_wb_nobypass_busy", SelNbBusy, 32'd3);
    expect_val("r7_wb_bypass_rd", SelRd0, 32'd77);
    step();
    wb_we = 1'b0;
    expect_val("r7_cleared", SelBusy, 32'd0);
    expect_val("r7_nb_cleared", SelNbBusy, 32'd0);
    expect_val("r7_rd", SelRd0, 32'd77);
    step();
    id_set = 1'b1; id_setR = 5'd7; wb_we = 1'b1; wb_wR = 5'd7; wb_wD = 32'd88;
    step();
    id_set = 1'b0; wb_we = 1'b0;
    expect_val("r7_set_wins", SelBusy, 32'd3);
    expect_val("r7_rd_88", SelRd0, 32'd88);
    step();
    wb_we = 1'b1; wb_wR = 5'd7; wb_wD = 32'd88;
    step();
    wb_we = 1'b0;
    expect_val("r7_final_clear", SelBusy, 32'd0);

    // Flush beats a same-cycle issue.
    step(); id_set = 1'b1; id_setR = 5'd3;
    step(); id_setR = 5'd9;
    step(); id_setR = 5'd12;
    step();
    id_set = 1'b0;
    rd_addr(5'd3, 5'd9);
    expect_val("pre_flush_3_9", SelBusy, 32'd3);
    rd_addr(5'd12, 5'd9);
    #1;
    expect_val("pre_flush_12_9", SelBusy, 32'd3);
    step();
    id_flush = 1'b1; id_set = 1'b1; id_setR = 5'd15;
    step();
    id_flush = 1'b0; id_set = 1'b0;
    rd_addr(5'd3, 5'd9);
    expect_val("flush_3_9", SelBusy, 32'd0);
    step();
    rd_addr(5'd12, 5'd15);
    expect_val("flush_12_15", SelBusy, 32'd0);

    // Reset in READY with state present, then again mid-sweep.
    step();
    id_set = 1'b1; id_setR = 5'd9;
    step();
    id_set = 1'b0;
    rd_addr(5'd5, 5'd9);
    expect_val("pre_rst_busy9", SelBusy, 32'd2);
    expect_val("pre_rst_r5", SelRd0, 32'hDEADBEEF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_val("rst2_init", SelInit, 32'd0);
    expect_val("rst2_rd_gated", SelRd0, 32'd0);
    for (int c = 1; c <= 10; c++) step();
    expect_val("mid_sweep_init", SelInit, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wb_we = 1'b1; wb_wR = 5'd20; wb_wD = 32'hCAFEF00D;
    sweep_check(5, "rst3a");
    wb_we = 1'b0;
    sweep_check(27, "rst3b");
    rd_addr(5'd5, 5'd9);
    expect_val("post_rst_r5", SelRd0, 32'd0);
    expect_val("post_rst_busy", SelBusy, 32'd0);
    rd_addr(5'd7, 5'd20);
    #1;
    expect_val("post_rst_r7", SelRd0, 32'd0);
    expect_val("post_rst_r20", SelRd1, 32'd0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
